// File: rtl/eth_pkg.sv
// Shared Ethernet MAC receive definitions: frame-length limits, CRC polynomial,
// controller state encoding and the per-frame status bundle.
package eth_pkg;

    localparam int ETH_MIN_WORDS = 16;
    localparam int ETH_MAX_WORDS = 380;
    localparam int ETH_LEN_W     = 16;

    localparam logic [31:0] ETH_CRC_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        CHECK
    } crc_rx_ctrl_state_e;

    typedef struct packed {
        logic                 ok;
        logic                 err;
        logic                 runt;
        logic                 giant;
        logic                 abort;
        logic [ETH_LEN_W-1:0] len;
    } crc_rx_status_t;

endpackage

// File: rtl/crc_rx.sv
// CRC accumulation engine: one SUM_W-bit word per cycle, MSB first, seed all-ones.
// Ports: clk, nreset, start_i (reseed), valid_i, data_i, crc_o (registered sum).
module crc_rx
    import eth_pkg::*;
#(
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [SUM_W-1:0] data_i,
    output logic [SUM_W-1:0] crc_o
);

    localparam logic [SUM_W-1:0] POLY = SUM_W'(ETH_CRC_POLY);

    logic [SUM_W-1:0] sum_q;

    function automatic logic [SUM_W-1:0] step(
        input logic [SUM_W-1:0] c,
        input logic [SUM_W-1:0] d
    );
        logic [SUM_W-1:0] r;
        r = c;
        for (int i = SUM_W - 1; i >= 0; i--) begin
            if (r[SUM_W-1] ^ d[i]) r = (r << 1) ^ POLY;
            else                   r = r << 1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sum_q <= '1;
        end else if (valid_i) begin
            sum_q <= step(start_i ? {SUM_W{1'b1}} : sum_q, data_i);
        end
    end

    assign crc_o = sum_q;

endmodule

// File: rtl/crc_rx_ctrl.sv
// Receive FCS sequencer: frames the word stream, feeds body words to crc_rx,
// holds back the FCS word, compares it to the residue and strobes a status.
// Ports: clk, nreset, valid_i/start_i/last_i/data_i in; busy_o, res_valid_o,
// crc_ok_o, crc_err_o, runt_o, giant_o, abort_o, len_o out.
// Build option: CRC_RX_CTRL_LEN_CHECK_EN enables the runt/giant comparators.
module crc_rx_ctrl
    import eth_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CRC_W     = 32,
    parameter int LEN_W     = 16,
    parameter int MIN_WORDS = ETH_MIN_WORDS,
    parameter int MAX_WORDS = ETH_MAX_WORDS
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              res_valid_o,
    output logic              crc_ok_o,
    output logic              crc_err_o,
    output logic              runt_o,
    output logic              giant_o,
    output logic              abort_o,
    output logic [LEN_W-1:0]  len_o
);

    crc_rx_ctrl_state_e state;
    crc_rx_status_t     stat_q;
    logic [LEN_W-1:0]   cnt;
    logic [DATA_W-1:0]  fcs;
    logic               zero_body;
    logic               res_valid;
    logic               eng_start;
    logic               eng_valid;
    logic [CRC_W-1:0]   eng_crc;

    crc_rx #(
        .SUM_W (CRC_W)
    ) m_crc_rx (
        .clk     (clk),
        .nreset  (nreset),
        .start_i (eng_start),
        .valid_i (eng_valid),
        .data_i  (CRC_W'(data_i)),
        .crc_o   (eng_crc)
    );

    // The FCS word never reaches the engine; a start word re-seeds it.
    always_comb begin
        eng_start = 1'b0;
        eng_valid = 1'b0;
        unique case (state)
            IDLE, CHECK: begin
                eng_start = valid_i & start_i & ~last_i;
                eng_valid = valid_i & start_i & ~last_i;
            end
            BODY: begin
                eng_start = valid_i & start_i & ~last_i;
                eng_valid = valid_i & ~last_i;
            end
            default: ;
        endcase
    end

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
        return (c == {LEN_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic crc_rx_status_t mk_status(
        input logic             ok,
        input logic             err,
        input logic             abort,
        input logic [LEN_W-1:0] c
    );
        crc_rx_status_t s;
        s       = '0;
        s.ok    = ok;
        s.err   = err;
        s.abort = abort;
        s.len   = ETH_LEN_W'(c);
`ifdef CRC_RX_CTRL_LEN_CHECK_EN
        s.runt  = (c < LEN_W'(MIN_WORDS));
        s.giant = (c > LEN_W'(MAX_WORDS));
`endif
        return s;
    endfunction

    logic crc_bad;
    assign crc_bad = zero_body | (eng_crc != CRC_W'(fcs));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            cnt       <= '0;
            fcs       <= '0;
            zero_body <= 1'b0;
            stat_q    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_i && start_i) begin
                        cnt       <= LEN_W'(1);
                        zero_body <= last_i;
                        state     <= last_i ? CHECK : BODY;
                    end
                end
                BODY: begin
                    if (valid_i && start_i) begin
                        // Truncated frame reports now; the word opens a new one.
                        res_valid <= 1'b1;
                        stat_q    <= mk_status(1'b0, 1'b0, 1'b1, cnt);
                        cnt       <= LEN_W'(1);
                        zero_body <= last_i;
                        state     <= last_i ? CHECK : BODY;
                    end else if (valid_i && last_i) begin
                        fcs   <= data_i;
                        cnt   <= sat_inc(cnt);
                        state <= CHECK;
                    end else if (valid_i) begin
                        cnt <= sat_inc(cnt);
                    end
                end
                CHECK: begin
                    res_valid <= 1'b1;
                    stat_q    <= mk_status(~crc_bad, crc_bad, 1'b0, cnt);
                    if (valid_i && start_i) begin
                        cnt       <= LEN_W'(1);
                        zero_body <= last_i;
                        state     <= last_i ? CHECK : BODY;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state != IDLE);
    assign res_valid_o = res_valid;
    assign crc_ok_o    = stat_q.ok;
    assign crc_err_o   = stat_q.err;
    assign runt_o      = stat_q.runt;
    assign giant_o     = stat_q.giant;
    assign abort_o     = stat_q.abort;
    assign len_o       = LEN_W'(stat_q.len);

endmodule

// File: tb/tb_crc_rx_ctrl.sv
// Directed bench for crc_rx_ctrl: good/bad FCS, abort, back-to-back,
// zero-body, runt/giant lengths and asynchronous reset mid-frame.
module tb_crc_rx_ctrl;

`ifdef CRC_RX_CTRL_LEN_CHECK_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        valid_i = 1'b0;
    logic        start_i = 1'b0;
    logic        last_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        busy_o, res_valid_o, crc_ok_o, crc_err_o;
    logic        runt_o, giant_o, abort_o;
    logic [15:0] len_o;

    crc_rx_ctrl dut (
        .clk         (clk),
        .nreset      (nreset),
        .valid_i     (valid_i),
        .start_i     (start_i),
        .last_i      (last_i),
        .data_i      (data_i),
        .busy_o      (busy_o),
        .res_valid_o (res_valid_o),
        .crc_ok_o    (crc_ok_o),
        .crc_err_o   (crc_err_o),
        .runt_o      (runt_o),
        .giant_o     (giant_o),
        .abort_o     (abort_o),
        .len_o       (len_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          cy;
        logic        ok, err, runt, giant, abort;
        logic [15:0] len;
    } strobe_t;

    strobe_t q[$];

    always @(negedge clk)
        if (res_valid_o)
            q.push_back('{cyc + 1, crc_ok_o, crc_err_o, runt_o, giant_o,
                          abort_o, len_o});

    // Byte-table CRC-32, MSB first, seed all-ones, no final inversion.
    logic [31:0] tbl[256];

    task automatic build_tbl();
        logic [31:0] c;
        for (int b = 0; b < 256; b++) begin
            c = 32'(b) << 24;
            for (int k = 0; k < 8; k++)
                c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
            tbl[b] = c;
        end
    endtask

    function automatic logic [31:0] crc_word(input logic [31:0] c,
                                             input logic [31:0] w);
        logic [7:0] idx;
        for (int b = 3; b >= 0; b--) begin
            idx = c[31:24] ^ w[8*b +: 8];
            c   = (c << 8) ^ tbl[idx];
        end
        return c;
    endfunction

    task automatic drive(input bit v, input bit s, input bit l,
                         input logic [31:0] d, output int cy);
        @(negedge clk);
        cy      = cyc + 1;
        valid_i = v;
        start_i = s;
        last_i  = l;
        data_i  = d;
    endtask

    task automatic idle_n(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
            start_i = 1'b0;
            last_i  = 1'b0;
        end
    endtask

    // nbody body words then the FCS word; gap>0 inserts idle cycles.
    task automatic send_frame(input int nbody, input logic [31:0] seed,
                              input bit bad_fcs, input int gap,
                              output int first_cy, output int lcy);
        logic [31:0] c, w;
        int          cy;
        c        = 32'hFFFF_FFFF;
        first_cy = -1;
        for (int i = 0; i < nbody; i++) begin
            w = seed + 32'(i) * 32'h0103_0507;
            if (gap != 0 && i % gap == 1) drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, cy);
            drive(1'b1, i == 0, 1'b0, w, cy);
            if (i == 0) first_cy = cy;
            c = crc_word(c, w);
        end
        drive(1'b1, nbody == 0, 1'b1, bad_fcs ? (c ^ 32'h1) : c, lcy);
        if (nbody == 0) first_cy = lcy;
    endtask

    task automatic expect_strobe(input string tag, input int cy,
                                 input bit ok, input bit err, input bit ab,
                                 input bit rn, input bit gi, input int len);
        strobe_t s;
        for (int k = 0; k < 8 && q.size() == 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() == 0) begin
            chk({tag, " strobe"}, 32'd0, 32'd1);
            return;
        end
        s = q.pop_front();
        chk({tag, " cycle"}, 32'(s.cy), 32'(cy));
        chk({tag, " ok"},    32'(s.ok),  32'(ok));
        chk({tag, " err"},   32'(s.err), 32'(err));
        chk({tag, " abort"}, 32'(s.abort), 32'(ab));
        chk({tag, " runt"},  32'(s.runt),  32'(rn));
        chk({tag, " giant"}, 32'(s.giant), 32'(gi));
        chk({tag, " len"},   32'(s.len),   32'(len));
    endtask

    int f1, l1, f2, l2, fa, la, dummy;

    initial begin
        build_tbl();
        repeat (3) @(negedge clk);
        chk("rst busy",  32'(busy_o), 32'd0);
        chk("rst rv",    32'(res_valid_o), 32'd0);
        chk("rst ok",    32'(crc_ok_o), 32'd0);
        chk("rst err",   32'(crc_err_o), 32'd0);
        chk("rst abort", 32'(abort_o), 32'd0);
        chk("rst len",   32'(len_o), 32'd0);
        nreset = 1'b1;

        // Stray words before any start are dropped.
        drive(1'b1, 1'b0, 1'b0, 32'h1234_5678, dummy);
        drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, dummy);
        idle_n(3);
        chk("drop nostrobe", 32'(q.size()), 32'd0);
        chk("drop busy", 32'(busy_o), 32'd0);

        // Good 16-word frame.
        send_frame(15, 32'hA5A5_0001, 1'b0, 0, f1, l1);
        @(negedge clk);
        valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
        chk("good busy in check", 32'(busy_o), 32'd1);
        expect_strobe("good", l1 + 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        idle_n(3);
        chk("hold len", 32'(len_o), 32'd16);
        chk("hold ok", 32'(crc_ok_o), 32'd1);
        chk("hold rv", 32'(res_valid_o), 32'd0);
        chk("idle busy", 32'(busy_o), 32'd0);

        // Same frame, FCS bit 0 flipped.
        send_frame(15, 32'hA5A5_0001, 1'b1, 0, f1, l1);
        idle_n(1);
        expect_strobe("badfcs", l1 + 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16);

        // Abort after 3 body words, then a complete good frame.
        drive(1'b1, 1'b1, 1'b0, 32'h0BAD_0000, dummy);
        drive(1'b1, 1'b0, 1'b0, 32'h0BAD_0001, dummy);
        drive(1'b1, 1'b0, 1'b0, 32'h0BAD_0002, dummy);
        send_frame(15, 32'h3C3C_7000, 1'b0, 0, fa, la);
        idle_n(1);
        expect_strobe("abort", fa + 1, 1'b0, 1'b0, 1'b1, LC, 1'b0, 3);
        expect_strobe("after abort", la + 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16);

        // Back-to-back frames, second one with idle gaps inside.
        send_frame(15, 32'h1111_0000, 1'b0, 0, f1, l1);
        send_frame(15, 32'h2222_0000, 1'b0, 4, f2, l2);
        idle_n(1);
        chk("b2b start", 32'(f2), 32'(l1 + 1));
        expect_strobe("b2b 1", l1 + 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        expect_strobe("b2b 2", l2 + 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16);

        // Zero-body frame: start and last on one word.
        send_frame(0, 32'h0, 1'b0, 0, f1, l1);
        idle_n(1);
        expect_strobe("zero", l1 + 2, 1'b0, 1'b1, 1'b0, LC, 1'b0, 1);

        // Runt: 4 words including FCS.
        send_frame(3, 32'h5555_0000, 1'b0, 0, f1, l1);
        idle_n(1);
        expect_strobe("runt", l1 + 2, 1'b1, 1'b0, 1'b0, LC, 1'b0, 4);

        // Giant: 400 words including FCS.
        send_frame(399, 32'h7777_0000, 1'b0, 0, f1, l1);
        idle_n(1);
        expect_strobe("giant", l1 + 2, 1'b1, 1'b0, 1'b0, 1'b0, LC, 400);

        // Reset mid-body with gaps.
        drive(1'b1, 1'b1, 1'b0, 32'hCAFE_0000, dummy);
        drive(1'b0, 1'b0, 1'b0, 32'h0, dummy);
        drive(1'b1, 1'b0, 1'b0, 32'hCAFE_0001, dummy);
        drive(1'b0, 1'b0, 1'b0, 32'h0, dummy);
        chk("pre-rst busy", 32'(busy_o), 32'd1);
        chk("pre-rst len", 32'(len_o), 32'd400);
        #2 nreset = 1'b0;
        #1;
        chk("rst busy mid", 32'(busy_o), 32'd0);
        chk("rst len mid", 32'(len_o), 32'd0);
        chk("rst ok mid", 32'(crc_ok_o), 32'd0);
        chk("rst giant mid", 32'(giant_o), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'hCAFE_0002, dummy);
        drive(1'b1, 1'b0, 1'b1, 32'hCAFE_0003, dummy);
        idle_n(4);
        chk("rst nostrobe", 32'(q.size()), 32'd0);
        send_frame(15, 32'h9999_0000, 1'b0, 3, f1, l1);
        idle_n(1);
        expect_strobe("post rst", l1 + 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16);

        idle_n(4);
        chk("no extra strobes", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
